alu_cmd_pipe: RTL and testbench

Registered command front-end and result capture stage for the combinational N-bit ALU. Buffers {ctrl, a, b, tag} commands from an upstream valid/ready source in a small FIFO and presents the FIFO head on the ALU operand ports. Captures the ALU result and flags into an output register with a valid/ready handshake, and keeps sticky status and an illegal-opcode counter for the downstream consumer.

---
 rtl/alu_cmd_pipe.sv | 154 +++++++++++++++
 tb/tb_alu_cmd_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_pipe.sv
// Command FIFO front-end and result capture stage wrapped around an external
// combinational ALU, with sticky status flags and an illegal-opcode counter.
module alu_cmd_pipe #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ctrl,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [N-1:0]     alu_a,
    output logic [N-1:0]     alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [N-1:0]     alu_result,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       out_ctrl,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic             sticky_carry,
    output logic [7:0]       illegal_cnt,
    output logic [AW:0]      occupancy
);

    logic [3:0]       r_mem_ctrl [DEPTH];
    logic [N-1:0]     r_mem_a    [DEPTH];
    logic [N-1:0]     r_mem_b    [DEPTH];
    logic [TAG_W-1:0] r_mem_tag  [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             r_out_valid;
    logic [N-1:0]     r_out_result;
    logic [3:0]       r_out_flags;
    logic [3:0]       r_out_ctrl;
    logic [TAG_W-1:0] r_out_tag;
    logic             r_sticky_ovf;
    logic             r_sticky_carry;
    logic [7:0]       r_illegal_cnt;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_push_inc;
    logic [AW:0]      w_pop_dec;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full;

    // Flush wins over both push and capture so nothing survives the flush edge.
    assign w_push   = in_valid && !w_full && !flush;
    assign w_pop    = !w_empty && (!r_out_valid || out_ready) && !flush;

    assign w_push_inc = {{AW{1'b0}}, w_push};
    assign w_pop_dec  = {{AW{1'b0}}, w_pop};

    assign alu_a    = w_empty ? '0 : r_mem_a[r_rd_ptr];
    assign alu_b    = w_empty ? '0 : r_mem_b[r_rd_ptr];
    assign alu_ctrl = w_empty ? '0 : r_mem_ctrl[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ctrl[r_wr_ptr] <= in_ctrl;
            r_mem_a[r_wr_ptr]    <= in_a;
            r_mem_b[r_wr_ptr]    <= in_b;
            r_mem_tag[r_wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + w_push_inc - w_pop_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_ctrl   <= '0;
            r_out_tag    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_flags  <= {alu_zero, alu_negative, alu_overflow, alu_carry};
            r_out_ctrl   <= alu_ctrl;
            r_out_tag    <= r_mem_tag[r_rd_ptr];
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A capture coinciding with clr_sticky clears first, then ORs in the new flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_ovf   <= 1'b0;
            r_sticky_carry <= 1'b0;
            r_illegal_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_sticky_ovf   <= (r_sticky_ovf & ~clr_sticky) | alu_overflow;
                r_sticky_carry <= (r_sticky_carry & ~clr_sticky) | alu_carry;
            end else if (clr_sticky) begin
                r_sticky_ovf   <= 1'b0;
                r_sticky_carry <= 1'b0;
            end
            if (w_pop && (alu_ctrl == 4'hF) && (r_illegal_cnt != 8'hFF)) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_flags    = r_out_flags;
    assign out_ctrl     = r_out_ctrl;
    assign out_tag      = r_out_tag;
    assign sticky_ovf   = r_sticky_ovf;
    assign sticky_carry = r_sticky_carry;
    assign illegal_cnt  = r_illegal_cnt;
    assign occupancy    = r_count;

endmodule

// File: tb/tb_alu_cmd_pipe.sv
// Randomized scoreboard bench for alu_cmd_pipe with a behavioural ALU and
// a queue-based model of the command/result path.
module tb_alu_cmd_pipe;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_ctrl;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [3:0]       alu_ctrl;
    logic [N-1:0]     alu_result;
    logic             alu_zero;
    logic             alu_negative;
    logic             alu_overflow;
    logic             alu_carry;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_result;
    logic [3:0]       out_flags;
    logic [3:0]       out_ctrl;
    logic [TAG_W-1:0] out_tag;
    logic             flush;
    logic             clr_sticky;
    logic             sticky_ovf;
    logic             sticky_carry;
    logic [7:0]       illegal_cnt;
    logic [2:0]       occupancy;

    always #5 clk = ~clk;

    alu_cmd_pipe #(.N(N), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_negative(alu_negative),
        .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_ctrl(out_ctrl), .out_tag(out_tag),
        .flush(flush), .clr_sticky(clr_sticky),
        .sticky_ovf(sticky_ovf), .sticky_carry(sticky_carry),
        .illegal_cnt(illegal_cnt), .occupancy(occupancy)
    );

    // Behavioural ALU: returns {zero, negative, overflow, carry, result}.
    // 0=ADD 1=SUB(carry = no borrow) 2=AND 3=OR 4=XOR, anything else yields 0.
    function automatic logic [35:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] wide;
        logic [31:0] r;
        logic        v;
        logic        cy;
        wide = '0; r = '0; v = 1'b0; cy = 1'b0;
        case (c)
            4'h0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[31:0]; cy = wide[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                r = a - b; cy = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            default: r = '0;
        endcase
        return {(r == 32'd0), r[31], v, cy, r};
    endfunction

    assign {alu_zero, alu_negative, alu_overflow, alu_carry, alu_result} = alu_f(alu_ctrl, alu_a, alu_b);

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  flg;
    } cmd_t;

    // sb holds every accepted, undelivered command in order: the held result
    // first (when m_ov), then the queued commands.
    cmd_t sb[$];
    int   m_cnt;
    int   m_ov;
    logic m_sov;
    logic m_scy;
    int   m_ill;
    int   n_tests;
    int   n_fail;
    logic end_req;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        cmd_t nc;
        cmd_t cap;
        logic [35:0] rv;
        bit hs;
        bit push;
        bit pop;
        n_tests = 0; n_fail = 0;
        m_cnt = 0; m_ov = 0; m_sov = 1'b0; m_scy = 1'b0; m_ill = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete(); m_cnt = 0; m_ov = 0; m_sov = 1'b0; m_scy = 1'b0; m_ill = 0;
                #1;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_occupancy", 64'(occupancy), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                chk("rst_sticky", 64'({sticky_ovf, sticky_carry}), 64'd0);
                chk("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
                chk("rst_out_fields", 64'({out_result, out_flags, out_ctrl, out_tag}), 64'd0);
            end else if (end_req) begin
                chk("drain_empty", 64'(sb.size()), 64'd0);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end else begin
                chk("occupancy", 64'(occupancy), 64'(m_cnt));
                chk("in_ready", 64'(in_ready), 64'(m_cnt < DEPTH));
                chk("out_valid", 64'(out_valid), 64'(m_ov));
                chk("sticky_ovf", 64'(sticky_ovf), 64'(m_sov));
                chk("sticky_carry", 64'(sticky_carry), 64'(m_scy));
                chk("illegal_cnt", 64'(illegal_cnt), 64'(m_ill));
                if (m_cnt == 0) begin
                    chk("alu_idle", 64'({alu_a, alu_b, alu_ctrl}), 64'd0);
                end else if (sb.size() > m_ov) begin
                    chk("alu_drive", 64'({alu_a, alu_b, alu_ctrl}),
                        64'({sb[m_ov].a, sb[m_ov].b, sb[m_ov].ctrl}));
                end

                hs   = (m_ov != 0) && out_ready && !flush;
                push = in_valid && (m_cnt < DEPTH) && !flush;
                pop  = (m_cnt > 0) && ((m_ov == 0) || out_ready) && !flush;

                if (hs && sb.size() > 0) begin
                    chk("out_result", 64'(out_result), 64'(sb[0].res));
                    chk("out_flags", 64'(out_flags), 64'(sb[0].flg));
                    chk("out_ctrl", 64'(out_ctrl), 64'(sb[0].ctrl));
                    chk("out_tag", 64'(out_tag), 64'(sb[0].tag));
                    $display("[TB] out tag=%0d ctrl=%0h a=%08h b=%08h res=%08h flags=%b",
                             out_tag, out_ctrl, sb[0].a, sb[0].b, out_result, out_flags);
                end
                if (pop && sb.size() > m_ov) begin
                    cap = sb[m_ov];
                    m_sov = (m_sov & ~clr_sticky) | cap.flg[1];
                    m_scy = (m_scy & ~clr_sticky) | cap.flg[0];
                    if (cap.ctrl == 4'hF && m_ill < 255) m_ill++;
                end else if (clr_sticky) begin
                    m_sov = 1'b0;
                    m_scy = 1'b0;
                end

                if (flush) begin
                    sb.delete(); m_cnt = 0; m_ov = 0;
                end else begin
                    if (hs) void'(sb.pop_front());
                    if (push) begin
                        rv = alu_f(in_ctrl, in_a, in_b);
                        nc.ctrl = in_ctrl; nc.a = in_a; nc.b = in_b; nc.tag = in_tag;
                        nc.res = rv[31:0]; nc.flg = rv[35:32];
                        sb.push_back(nc);
                    end
                    m_cnt = m_cnt + int'(push) - int'(pop);
                    m_ov  = pop ? 1 : (out_ready ? 0 : m_ov);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] t);
        in_valid = v; in_ctrl = c; in_a = a; in_b = b; in_tag = t;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        end_req = 1'b0;
        rst_n = 1'b1;
        drive(1'b0, 4'h0, 32'd0, 32'd0, 4'd0);
        out_ready = 1'b1; flush = 1'b0; clr_sticky = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();

        // ADD overflow into the sign bit
        drive(1'b1, 4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3);
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();

        // Fill with the consumer stalled: 5 accepted, then full
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'($urandom_range(0, 4)), $urandom, $urandom, 4'(i));
            cyc();
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        out_ready = 1'b1;
        repeat (8) cyc();

        // Illegal opcodes, enough to saturate the counter
        for (int i = 0; i < 303; i++) begin
            drive(1'b1, 4'hF, $urandom, $urandom, 4'(i));
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();

        // Flush with a full output register and queued commands
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'h2, $urandom, $urandom, 4'(8 + i));
            cyc();
        end
        drive(1'b1, 4'h3, 32'h1234_5678, 32'h0F0F_0F0F, 4'd15);
        flush = 1'b1;
        cyc();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cyc();

        // clr_sticky coinciding with an overflowing capture, then alone
        clr_sticky = 1'b1;
        cyc();
        clr_sticky = 1'b0;
        drive(1'b1, 4'h1, 32'h8000_0000, 32'h0000_0001, 4'd7);
        cyc();
        in_valid = 1'b0; clr_sticky = 1'b1;
        cyc();
        cyc();
        clr_sticky = 1'b0;
        repeat (2) cyc();

        // Random traffic with occasional flush and sticky clears
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick_op(), pick_op(), 4'($urandom));
            out_ready  = $urandom_range(0, 3) != 0;
            flush      = $urandom_range(0, 39) == 0;
            clr_sticky = $urandom_range(0, 19) == 0;
            cyc();
        end
        flush = 1'b0; clr_sticky = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) cyc();

        // Reset asserted between clock edges with traffic in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'h1, pick_op(), pick_op(), 4'(i));
            cyc();
        end
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        cyc();
        drive(1'b1, 4'h0, 32'd100, 32'd23, 4'd9);
        cyc();
        in_valid = 1'b0;

        for (int i = 0; i < 50 && sb.size() != 0; i++) cyc();
        end_req = 1'b1;
        repeat (5) cyc();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
